ft600_tx_packer: RTL and testbench
==================================

Name: ft600_tx_packer

Overview:
- Upstream neighbour of ft600_mode245 on the transmit path.
- Accepts a byte stream with a valid/ready handshake and packs it into the flat transmit buffer (tx_buf) that ft600_mode245 drains.
- Hands each full or flushed buffer over with the 4-bit send/sent sequence-token handshake.
- Reports backpressure on stalled.

Parameters:
- TX_BUF_WIDTH, 4: buffer holds 1<<TX_BUF_WIDTH bytes; tx_buf is 8<<TX_BUF_WIDTH bits.
- FLUSH_TIMEOUT, 1024: idle cycles with a partial buffer before an automatic flush; 0 disables the timeout.
- PAD_BYTE, 8'h00: value written into unused byte lanes on a flush.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  in  8  input byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  with a valid byte: this byte ends a message; flush after it.
- in_ready  out  1  block accepts in_data this cycle.
- tx_buf  out  8<<TX_BUF_WIDTH  packed buffer; byte k occupies bits [8k+7:8k].
- tx_buf_send  out  4  sequence token; incremented mod 16 when a buffer is handed over.
- tx_buf_sent  in  4  token returned by ft600_mode245; equals tx_buf_send when the buffer has been consumed.
- stalled  out  1  in_valid high while in_ready low.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx_buf all zero, tx_buf_send=0, in_ready=0, stalled=0.
  - Byte index=0, idle counter=0, state=FILL.
  - Resetting mid-operation discards any partial buffer.
  - tx_buf_sent is ignored during reset.
- First cycle after reset release: in_ready=1 provided tx_buf_sent==tx_buf_send; otherwise the block enters WAIT_SENT.
- State FILL:
  - in_ready=1.
  - Transfer occurs when in_valid and in_ready are both 1: in_data is written to lane idx; idx increments; idle counter clears.
  - If idx was the last lane (2^TX_BUF_WIDTH-1), or in_last=1: lanes above idx are written with PAD_BYTE in the same cycle; tx_buf_send increments mod 16 on that edge; idx returns to 0; next state WAIT_SENT.
  - A full buffer coinciding with in_last causes exactly one handover, not two.
- Timeout flush:
  - In FILL with idx>0 and no transfer, the idle counter increments.
  - When it reaches FLUSH_TIMEOUT, lanes idx..end are padded, tx_buf_send increments, and the state goes to WAIT_SENT.
  - An empty buffer (idx==0) never flushes and never hands over.
- State WAIT_SENT:
  - in_ready=0; tx_buf is held bit-stable.
  - Transition to FILL in the cycle after tx_buf_sent==tx_buf_send is sampled. in_ready is registered, so it rises one cycle after equality.
- Token rules:
  - Wrap 15->0 is normal.
  - A tx_buf_sent value other than tx_buf_send or tx_buf_send-1 is a protocol error. The block keeps waiting for equality and does not re-send.
- stalled: combinational in_valid & ~in_ready.
- Latency: the handover edge is the same edge that accepts the final byte. At most one buffer is outstanding.
- Outputs in_ready and tx_buf_send are registered. tx_buf_sent is synchronous to clk.

Test Plan:
- Reset then 16 bytes 0x00..0x0F, continuous valid, sent echoed 3 cycles after send changes -> tx_buf=128'h0F0E..0100; tx_buf_send 0->1 on the 16th accept edge; in_ready low for 4 cycles, then high.
- 3 bytes AA,BB,CC with in_last on CC -> tx_buf lanes 0..2=AA,BB,CC, lanes 3..15=00; send increments once.
- FLUSH_TIMEOUT=8; 2 bytes then valid low -> flush exactly 8 idle cycles after the 2nd accept; lanes 2..15 padded; no flush while empty afterwards.
- Hold tx_buf_sent stale for 100 cycles with in_valid high -> in_ready=0 and stalled=1 throughout; tx_buf unchanged; no bytes lost after release.
- 17 consecutive buffers -> tx_buf_send wraps 15->0; handshake still completes.
- Assert rst low mid-buffer after 5 bytes -> all outputs zero immediately; after release, new bytes start at lane 0.

Source files
------------

// File: rtl/ft600_tx_packer_if.sv
// rtl/ft600_tx_packer_if.sv - byte-stream and transmit-buffer handshake bundle for ft600_tx_packer
interface ft600_tx_packer_if #(
  parameter int TX_BUF_WIDTH = 4
);
  logic [7:0]                      in_data;
  logic                            in_valid;
  logic                            in_last;
  logic                            in_ready;
  logic [(8<<TX_BUF_WIDTH)-1:0]    tx_buf;
  logic [3:0]                      tx_buf_send;
  logic [3:0]                      tx_buf_sent;
  logic                            stalled;

  modport master (
    output in_data, in_valid, in_last, tx_buf_sent,
    input  in_ready, tx_buf, tx_buf_send, stalled
  );

  modport slave (
    input  in_data, in_valid, in_last, tx_buf_sent,
    output in_ready, tx_buf, tx_buf_send, stalled
  );
endinterface

// File: rtl/ft600_tx_packer.sv
// rtl/ft600_tx_packer.sv - packs a byte stream into the flat tx buffer and hands it over by token
module ft600_tx_packer #(
  parameter int         TX_BUF_WIDTH  = 4,
  parameter int         FLUSH_TIMEOUT = 1024,
  parameter logic [7:0] PAD_BYTE      = 8'h00
) (
  input logic            clk,
  input logic            rst,
  ft600_tx_packer_if.slave bus
);
  localparam int LANES = 1 << TX_BUF_WIDTH;
  localparam int BUF_W = 8 * LANES;
  localparam int CNT_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]        CNT_LAST = (FLUSH_TIMEOUT > 0) ? CNT_W'(FLUSH_TIMEOUT - 1) : '0;
  localparam logic [TX_BUF_WIDTH-1:0] IDX_LAST = '1;

  typedef enum logic {FILL, WAIT_SENT} state_t;

  state_t                  state_q, state_d;
  logic [TX_BUF_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BUF_W-1:0]        buf_q, buf_d;
  logic [3:0]              send_q, send_d;
  logic                    ready_q, ready_d;
  logic                    last_byte;
  logic                    token_match;

  assign token_match = (bus.tx_buf_sent == send_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      send_q  <= 4'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      send_q  <= send_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    send_d    = send_q;
    ready_d   = ready_q;
    last_byte = 1'b0;

    case (state_q)
      FILL: begin
        if (!ready_q) begin
          // FILL with in_ready low only happens on the first cycle out of reset
          if (token_match) begin
            ready_d = 1'b1;
          end else begin
            state_d = WAIT_SENT;
          end
        end else if (bus.in_valid) begin
          last_byte = (idx_q == IDX_LAST) || bus.in_last;
          cnt_d     = '0;
          for (int k = 0; k < LANES; k++) begin
            if (k == int'(idx_q)) begin
              buf_d[8*k +: 8] = bus.in_data;
            end else if (last_byte && (k > int'(idx_q))) begin
              buf_d[8*k +: 8] = PAD_BYTE;
            end
          end
          if (last_byte) begin
            send_d  = send_q + 4'd1;
            idx_d   = '0;
            state_d = WAIT_SENT;
            ready_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if ((FLUSH_TIMEOUT != 0) && (idx_q != '0)) begin
          if (cnt_q == CNT_LAST) begin
            for (int k = 0; k < LANES; k++) begin
              if (k >= int'(idx_q)) begin
                buf_d[8*k +: 8] = PAD_BYTE;
              end
            end
            send_d  = send_q + 4'd1;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = WAIT_SENT;
            ready_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT_SENT: begin
        // A stale or out-of-range token just keeps us here; nothing is re-sent
        if (token_match) begin
          state_d = FILL;
          ready_d = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.in_ready    = ready_q;
  assign bus.tx_buf      = buf_q;
  assign bus.tx_buf_send = send_q;
  assign bus.stalled     = rst & bus.in_valid & ~ready_q;
endmodule

// File: tb/tb_ft600_tx_packer.sv
// tb/tb_ft600_tx_packer.sv - directed table-driven bench for ft600_tx_packer
module tb_ft600_tx_packer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ft600_tx_packer_if #(.TX_BUF_WIDTH(4)) bus ();

  ft600_tx_packer #(
    .TX_BUF_WIDTH (4),
    .FLUSH_TIMEOUT(8),
    .PAD_BYTE     (8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [127:0] data;
    int           n;
    logic         use_last;
    logic [127:0] exp_buf;
    logic [3:0]   exp_send;
  } vec_t;

  vec_t         vecs[4];
  int           checks = 0;
  int           errors = 0;
  logic [3:0]   exp_send;
  logic [127:0] exp_buf;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("wait_ready", {127'b0, bus.in_ready}, 128'd1);
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = l;
    wait_ready();
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int low;
    int cyc;
    int bad;
    logic [7:0] bv;

    vecs[0] = '{128'h0F0E0D0C0B0A09080706050403020100, 16, 1'b0,
                128'h0F0E0D0C0B0A09080706050403020100, 4'd1};
    vecs[1] = '{128'hCCBBAA, 3, 1'b1, 128'h000000000000000000000000_00CCBBAA, 4'd2};
    vecs[2] = '{128'h5A, 1, 1'b1, 128'h5A, 4'd3};
    vecs[3] = '{128'h1F1E1D1C1B1A19181716151413121110, 16, 1'b1,
                128'h1F1E1D1C1B1A19181716151413121110, 4'd4};

    rst             = 1'b0;
    bus.in_data     = 8'h00;
    bus.in_valid    = 1'b0;
    bus.in_last     = 1'b0;
    bus.tx_buf_sent = 4'd0;
    exp_send        = 4'd0;
    repeat (2) tick();
    chk("reset_buf", bus.tx_buf, 128'd0);
    chk("reset_send", {124'b0, bus.tx_buf_send}, 128'd0);
    chk("reset_ready", {127'b0, bus.in_ready}, 128'd0);
    chk("reset_stalled", {127'b0, bus.stalled}, 128'd0);
    rst = 1'b1;
    tick();
    chk("ready_after_release", {127'b0, bus.in_ready}, 128'd1);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        push(vecs[v].data[8*i +: 8], vecs[v].use_last && (i == vecs[v].n - 1));
      end
      exp_send = vecs[v].exp_send;
      chk("vec_buf", bus.tx_buf, vecs[v].exp_buf);
      chk("vec_send", {124'b0, bus.tx_buf_send}, {124'b0, exp_send});
      low = (bus.in_ready === 1'b0) ? 1 : 0;
      repeat (3) begin
        tick();
        if (bus.in_ready === 1'b0) low++;
      end
      bus.tx_buf_sent = exp_send;
      tick();
      if (bus.in_ready === 1'b0) low++;
      chk("vec_ready_low_cycles", low, 128'd4);
      chk("vec_ready_after_echo", {127'b0, bus.in_ready}, 128'd1);
      chk("vec_send_single", {124'b0, bus.tx_buf_send}, {124'b0, exp_send});
    end

    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    cyc = 0;
    while (bus.tx_buf_send === exp_send && cyc < 20) begin
      tick();
      cyc++;
    end
    exp_send = 4'd5;
    chk("flush_delay", cyc, 128'd8);
    chk("flush_send", {124'b0, bus.tx_buf_send}, {124'b0, exp_send});
    chk("flush_buf", bus.tx_buf, 128'h2211);
    bus.tx_buf_sent = exp_send;
    tick();
    wait_ready();
    repeat (30) tick();
    chk("no_empty_flush", {124'b0, bus.tx_buf_send}, {124'b0, exp_send});
    chk("ready_when_empty", {127'b0, bus.in_ready}, 128'd1);

    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b0);
    exp_send = 4'd6;
    exp_buf  = 128'h2F2E2D2C2B2A29282726252423222120;
    chk("stall_pre_buf", bus.tx_buf, exp_buf);
    chk("stall_pre_send", {124'b0, bus.tx_buf_send}, {124'b0, exp_send});
    bus.in_data  = 8'h30;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (c == 50) bus.tx_buf_sent = 4'd12;
      tick();
      if (bus.in_ready !== 1'b0 || bus.stalled !== 1'b1 || bus.tx_buf !== exp_buf ||
          bus.tx_buf_send !== exp_send) bad++;
    end
    chk("stall_hold_bad_cycles", bad, 128'd0);
    bus.tx_buf_sent = exp_send;
    wait_ready();
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i < 16; i++) push(8'h30 + 8'(i), 1'b0);
    exp_send = 4'd7;
    chk("stall_after_buf", bus.tx_buf, 128'h3F3E3D3C3B3A39383736353433323130);
    chk("stall_after_send", {124'b0, bus.tx_buf_send}, {124'b0, exp_send});
    bus.tx_buf_sent = exp_send;

    for (int b = 0; b < 17; b++) begin
      bv = 8'h80 + 8'(b);
      push(bv, 1'b1);
      exp_send = exp_send + 4'd1;
      chk("wrap_send", {124'b0, bus.tx_buf_send}, {124'b0, exp_send});
      chk("wrap_buf", bus.tx_buf, {120'b0, bv});
      bus.tx_buf_sent = exp_send;
    end
    chk("wrap_final_send", {124'b0, bus.tx_buf_send}, 128'd8);
    wait_ready();

    for (int i = 0; i < 5; i++) push(8'h41 + 8'(i), 1'b0);
    bus.in_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("midrst_buf", bus.tx_buf, 128'd0);
    chk("midrst_send", {124'b0, bus.tx_buf_send}, 128'd0);
    chk("midrst_ready", {127'b0, bus.in_ready}, 128'd0);
    chk("midrst_stalled", {127'b0, bus.stalled}, 128'd0);
    bus.in_valid    = 1'b0;
    bus.tx_buf_sent = 4'd3;
    tick();
    rst = 1'b1;
    tick();
    chk("release_mismatch_ready", {127'b0, bus.in_ready}, 128'd0);
    tick();
    chk("release_wait_ready", {127'b0, bus.in_ready}, 128'd0);
    bus.tx_buf_sent = 4'd0;
    tick();
    chk("release_match_ready", {127'b0, bus.in_ready}, 128'd1);
    push(8'h61, 1'b0);
    push(8'h62, 1'b0);
    push(8'h63, 1'b1);
    chk("post_rst_buf", bus.tx_buf, 128'h636261);
    chk("post_rst_send", {124'b0, bus.tx_buf_send}, 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
